// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the multicycle stack-machine controller:
// opcodes, ALU operation codes and the FSM state type.
package stack_ctrl_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_PMEM, S_PWB, S_POPA, S_LDA, S_POPB,
        S_LDB, S_EXEC, S_NOT, S_AWB, S_STORE, S_JMP, S_JZ, S_ERROR
    } state_t;

endpackage

// File: rtl/stack_occ_counter.sv
// Tracks how many entries the hardware stack holds and flags the
// occupancy thresholds the controller checks before issuing strobes.
module stack_occ_counter #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             has1,
    output logic             has2
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc) begin
            count <= count - CNT_W'(1);
        end
    end

    assign full = (count == CNT_W'(DEPTH));
    assign has1 = (count != '0);
    assign has2 = (count >= CNT_W'(2));

endmodule

// File: rtl/stack_ctrl_param.sv
// Multicycle control FSM for the stack-machine datapath: sequences PC,
// memory, A/B latches, ALU and stack, with occupancy traps and sticky halt.
module stack_ctrl_param
    import stack_ctrl_pkg::*;
#(
    parameter  int INSTR_W = 8,
    parameter  int OPC_W   = 3,
    parameter  int DEPTH   = 8,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               pc_src,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               m_to_s,
    output logic               ld_a,
    output logic               ld_b,
    output logic               src_a,
    output logic               src_b,
    output logic [1:0]         alu_op,
    output logic               push,
    output logic               pop,
    output logic               tos,
    output logic [CNT_W-1:0]   stack_count,
    output logic               err_overflow,
    output logic               err_underflow,
    output logic               halted
);

    state_t           state;
    logic [OPC_W-1:0] opcode;
    logic [2:0]       op;
    logic             illegal;
    logic             operand_ok;
    logic             full, has1, has2;

    assign opcode  = instruction[INSTR_W-1 -: OPC_W];
    assign op      = opcode[2:0];
    assign illegal = ((opcode >> 3) != '0);

    // The zero flag gates the PC inside the datapath; operand bits are not decoded here.
    logic unused_bits;
    assign unused_bits = zero ^ (^instruction[INSTR_W-OPC_W-1:0]);

    always_comb begin
        operand_ok = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_AND: operand_ok = has2;
            OP_NOT, OP_POP, OP_JZ:  operand_ok = has1;
            OP_PUSH:                operand_ok = !full;
            default:                operand_ok = 1'b1;
        endcase
        if (illegal) operand_ok = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (!operand_ok) begin
                        state <= S_ERROR;
                        if (op == OP_PUSH && !illegal) err_overflow  <= 1'b1;
                        else                           err_underflow <= 1'b1;
                    end else begin
                        case (op)
                            OP_PUSH: state <= S_PMEM;
                            OP_JMP:  state <= S_JMP;
                            OP_JZ:   state <= S_JZ;
                            default: state <= S_POPA;
                        endcase
                    end
                end
                S_PMEM:   if (mem_ready) state <= S_PWB;
                S_PWB:    state <= S_FETCH;
                S_POPA:   state <= S_LDA;
                S_LDA: begin
                    case (op)
                        OP_NOT:  state <= S_NOT;
                        OP_POP:  state <= S_STORE;
                        default: state <= S_POPB;
                    endcase
                end
                S_POPB:   state <= S_LDB;
                S_LDB:    state <= S_EXEC;
                S_EXEC:   state <= S_AWB;
                S_NOT:    state <= S_AWB;
                S_AWB:    state <= S_FETCH;
                S_STORE:  if (mem_ready) state <= S_FETCH;
                S_JMP:    state <= S_FETCH;
                S_JZ:     state <= S_FETCH;
                default:  state <= S_ERROR;
            endcase
        end
    end

    // Outputs decode straight from the state register so reset silences them at once.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        m_to_s        = 1'b0;
        ld_a          = 1'b0;
        ld_b          = 1'b0;
        src_a         = 1'b0;
        src_b         = 1'b0;
        alu_op        = ALU_ADD;
        push          = 1'b0;
        pop           = 1'b0;
        tos           = 1'b0;
        halted        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: tos = 1'b1;
            S_PMEM: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_PWB: begin
                m_to_s = 1'b1;
                push   = 1'b1;
            end
            S_POPA, S_POPB: pop = 1'b1;
            S_LDA: ld_a = 1'b1;
            S_LDB: ld_b = 1'b1;
            S_EXEC: begin
                src_a  = 1'b1;
                src_b  = 1'b1;
                alu_op = op[1:0];
            end
            S_NOT: begin
                src_a  = 1'b1;
                alu_op = ALU_NOT;
            end
            S_AWB: push = 1'b1;
            S_STORE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_JMP: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
            end
            S_JZ: begin
                tos           = 1'b1;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
            end
            S_ERROR: halted = 1'b1;
            default: ;
        endcase
    end

    stack_occ_counter #(.DEPTH(DEPTH)) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (push),
        .dec   (pop),
        .count (stack_count),
        .full  (full),
        .has1  (has1),
        .has2  (has2)
    );

endmodule

// File: tb/tb_stack_ctrl_param.sv
// Scoreboard bench for stack_ctrl_param: a cycle-by-cycle expected output
// trace is queued per instruction and compared as the controller steps.
module tb_stack_ctrl_param;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk, rst, zero, mem_ready;
    logic [7:0]       instruction;
    logic             pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write;
    logic             ir_write, m_to_s, ld_a, ld_b, src_a, src_b, push, pop, tos;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] stack_count;
    logic             err_overflow, err_underflow, halted;

    stack_ctrl_param #(.INSTR_W(8), .OPC_W(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .m_to_s(m_to_s),
        .ld_a(ld_a), .ld_b(ld_b), .src_a(src_a), .src_b(src_b), .alu_op(alu_op),
        .push(push), .pop(pop), .tos(tos), .stack_count(stack_count),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write;
        logic       ir_write, m_to_s, ld_a, ld_b, src_a, src_b;
        logic [1:0] alu_op;
        logic       push, pop, tos, halted;
    } out_t;

    out_t dut_out;
    assign dut_out = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                      ir_write, m_to_s, ld_a, ld_b, src_a, src_b, alu_op,
                      push, pop, tos, halted};

    typedef enum int {
        PH_FETCH_W, PH_FETCH, PH_DECODE, PH_PMEM_W, PH_PMEM, PH_PWB, PH_POPA, PH_LDA,
        PH_POPB, PH_LDB, PH_EXEC, PH_NOT, PH_AWB, PH_STORE_W, PH_STORE, PH_JMP, PH_JZ, PH_ERROR
    } phase_t;

    typedef struct {
        phase_t ph;
        logic   rdy;
        out_t   exp;
        int     cnt;
    } entry_t;

    entry_t sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     model_cnt = 0;
    logic   model_ovf = 1'b0;
    logic   model_unf = 1'b0;

    function automatic out_t ph_out(input phase_t p, input logic [1:0] alu);
        out_t o;
        o = '0;
        case (p)
            PH_FETCH_W: o.mem_read = 1'b1;
            PH_FETCH:   begin o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1; end
            PH_DECODE:  o.tos = 1'b1;
            PH_PMEM_W, PH_PMEM: begin o.i_or_d = 1'b1; o.mem_read = 1'b1; end
            PH_PWB:     begin o.m_to_s = 1'b1; o.push = 1'b1; end
            PH_POPA, PH_POPB: o.pop = 1'b1;
            PH_LDA:     o.ld_a = 1'b1;
            PH_LDB:     o.ld_b = 1'b1;
            PH_EXEC:    begin o.src_a = 1'b1; o.src_b = 1'b1; o.alu_op = alu; end
            PH_NOT:     begin o.src_a = 1'b1; o.alu_op = 2'b11; end
            PH_AWB:     o.push = 1'b1;
            PH_STORE_W, PH_STORE: begin o.i_or_d = 1'b1; o.mem_write = 1'b1; end
            PH_JMP:     begin o.pc_write = 1'b1; o.pc_src = 1'b1; end
            PH_JZ:      begin o.tos = 1'b1; o.pc_write_cond = 1'b1; o.pc_src = 1'b1; end
            PH_ERROR:   o.halted = 1'b1;
            default:    ;
        endcase
        return o;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Queue one expected cycle; the count recorded is the pre-edge occupancy.
    task automatic add_ph(input phase_t p, input logic rdy, input logic [1:0] alu);
        entry_t e;
        e.ph  = p;
        e.rdy = rdy;
        e.exp = ph_out(p, alu);
        e.cnt = model_cnt;
        sb.push_back(e);
        if (p == PH_PWB || p == PH_AWB) model_cnt++;
        else if (p == PH_POPA || p == PH_POPB) model_cnt--;
    endtask

    task automatic run_instr(input logic [7:0] ins, input int fwait, input int mwait,
                             input int abort_at);
        logic [2:0] op;
        bit         bad;
        bit         ovf;
        entry_t     e;
        int         idx;
        op  = ins[7:5];
        bad = 1'b0;
        ovf = 1'b0;
        for (int i = 0; i < fwait; i++) add_ph(PH_FETCH_W, 1'b0, 2'b00);
        add_ph(PH_FETCH, 1'b1, 2'b00);
        add_ph(PH_DECODE, rnd_bit(), 2'b00);
        case (op)
            3'd0, 3'd1, 3'd2: bad = (model_cnt < 2);
            3'd3, 3'd5, 3'd7: bad = (model_cnt < 1);
            3'd4: begin bad = (model_cnt == DEPTH); ovf = bad; end
            default: bad = 1'b0;
        endcase
        if (bad) begin
            for (int i = 0; i < 3; i++) add_ph(PH_ERROR, rnd_bit(), 2'b00);
            if (ovf) model_ovf = 1'b1;
            else     model_unf = 1'b1;
        end else begin
            case (op)
                3'd4: begin
                    for (int i = 0; i < mwait; i++) add_ph(PH_PMEM_W, 1'b0, 2'b00);
                    add_ph(PH_PMEM, 1'b1, 2'b00);
                    add_ph(PH_PWB, rnd_bit(), 2'b00);
                end
                3'd0, 3'd1, 3'd2: begin
                    add_ph(PH_POPA, rnd_bit(), 2'b00);
                    add_ph(PH_LDA, rnd_bit(), 2'b00);
                    add_ph(PH_POPB, rnd_bit(), 2'b00);
                    add_ph(PH_LDB, rnd_bit(), 2'b00);
                    add_ph(PH_EXEC, rnd_bit(), op[1:0]);
                    add_ph(PH_AWB, rnd_bit(), 2'b00);
                end
                3'd3: begin
                    add_ph(PH_POPA, rnd_bit(), 2'b00);
                    add_ph(PH_LDA, rnd_bit(), 2'b00);
                    add_ph(PH_NOT, rnd_bit(), 2'b00);
                    add_ph(PH_AWB, rnd_bit(), 2'b00);
                end
                3'd5: begin
                    add_ph(PH_POPA, rnd_bit(), 2'b00);
                    add_ph(PH_LDA, rnd_bit(), 2'b00);
                    for (int i = 0; i < mwait; i++) add_ph(PH_STORE_W, 1'b0, 2'b00);
                    add_ph(PH_STORE, 1'b1, 2'b00);
                end
                3'd6: add_ph(PH_JMP, rnd_bit(), 2'b00);
                default: add_ph(PH_JZ, rnd_bit(), 2'b00);
            endcase
        end

        instruction = ins;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            mem_ready = e.rdy;
            zero      = rnd_bit();
            #1;
            n_tests++;
            if (dut_out !== e.exp) begin
                n_fail++;
                $display("FAIL outputs %s ins=%h cyc=%0d: got %h expected %h",
                         e.ph.name(), ins, idx, dut_out, e.exp);
            end
            n_tests++;
            if (stack_count !== CNT_W'(e.cnt)) begin
                n_fail++;
                $display("FAIL stack_count %s ins=%h cyc=%0d: got %0d expected %0d",
                         e.ph.name(), ins, idx, stack_count, e.cnt);
            end
            if (idx == abort_at) begin
                sb.delete();
                return;
            end
            idx++;
        end
        n_tests++;
        if ({err_overflow, err_underflow} !== {model_ovf, model_unf}) begin
            n_fail++;
            $display("FAIL err_flags ins=%h: got ovf=%b unf=%b expected ovf=%b unf=%b",
                     ins, err_overflow, err_underflow, model_ovf, model_unf);
        end
    endtask

    // Assert rst (immediately, or at the next falling edge), check the quiescent
    // state, then release so the following rising edge enters FETCH.
    task automatic do_reset(input bit immediate);
        if (!immediate) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (dut_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", dut_out);
        end
        n_tests++;
        if (stack_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", stack_count);
        end
        n_tests++;
        if ({err_overflow, err_underflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00", {err_overflow, err_underflow});
        end
        model_cnt = 0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (dut_out !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h expected 0", dut_out);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
    endtask

    task automatic test_push();
        run_instr(8'h85, 0, 0, -1);
    endtask

    task automatic test_alu();
        run_instr(8'h85, 0, 0, -1);
        run_instr(8'h00, 0, 0, -1);
        run_instr(8'h85, 0, 0, -1);
        run_instr(8'h20, 0, 0, -1);
        run_instr(8'h85, 0, 0, -1);
        run_instr(8'h40, 0, 0, -1);
        run_instr(8'h60, 0, 0, -1);
    endtask

    task automatic test_mem_wait();
        run_instr(8'h85, 0, 2, -1);
        run_instr(8'hA3, 3, 3, -1);
    endtask

    task automatic test_jumps();
        run_instr(8'hE7, 0, 0, -1);
        run_instr(8'hC0, 1, 0, -1);
    endtask

    task automatic test_underflow();
        do_reset(1'b0);
        run_instr(8'h85, 0, 0, -1);
        run_instr(8'h00, 0, 0, -1);
        do_reset(1'b0);
        run_instr(8'hE7, 0, 0, -1);
        do_reset(1'b0);
        run_instr(8'hA3, 0, 0, -1);
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) run_instr(8'h85, 0, 0, -1);
        run_instr(8'h85, 0, 0, -1);
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) run_instr(8'h85, 0, 0, -1);
        run_instr(8'h00, 0, 0, 5);
        do_reset(1'b1);
        run_instr(8'h85, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        do_reset(1'b0);
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op <= 3'd2 && model_cnt < 2) op = 3'd4;
            if ((op == 3'd3 || op == 3'd5 || op == 3'd7) && model_cnt < 1) op = 3'd4;
            if (op == 3'd4 && model_cnt == DEPTH) op = 3'd5;
            run_instr({op, 5'($urandom_range(0, 31))}, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instruction = 8'h00;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        test_reset();
        test_push();
        test_alu();
        test_mem_wait();
        test_jumps();
        test_underflow();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
